sram_fifo_ctrl: RTL and testbench
=================================

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, 50, data width, equal to the SRAM macro word; AW, 5, SRAM address width, giving 32 entries.
REQ-002 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 IN_VALID  in  1  producer offers IN_DATA.
REQ-005 IN_READY  out  1  controller accepts IN_DATA this cycle.
REQ-006 IN_DATA  in  WIDTH  write word.
REQ-007 OUT_VALID  out  1  OUT_DATA holds the head word.
REQ-008 OUT_READY  in  1  consumer takes the head word.
REQ-009 OUT_DATA  out  WIDTH  head word.
REQ-010 COUNT  out  6  total words held: SRAM, in-flight read and output buffer, range 0..34.
REQ-011 SRAM_A  out  AW  macro address.
REQ-012 SRAM_CSB  out  1  macro chip select, active low.
REQ-013 SRAM_WEB  out  1  macro write enable, active low.
REQ-014 SRAM_OEB  out  1  macro output enable; tied 0.
REQ-015 SRAM_I  out  WIDTH  macro write data; equals IN_DATA.
REQ-016 SRAM_O  in  WIDTH  macro read data; valid the cycle after a read edge.

Function
REQ-017 The block SHALL be a FIFO that stores words in a single-port 32x50 SRAM and performs at most one SRAM access per cycle.
REQ-018 State SHALL consist of: 5-bit write pointer wp, 5-bit read pointer rp, 6-bit sram_cnt (0..32), rd_inflight flag, and a 2-entry output buffer ob with occupancy ob_cnt (0..2).
REQ-019 Pointers SHALL increment modulo 32 (31 -> 0); full is sram_cnt==32; empty is sram_cnt==0.
REQ-020 Read grant rd_go SHALL be sram_cnt!=0 and (ob_cnt + rd_inflight - pop) < 2, where pop = OUT_VALID & OUT_READY.
REQ-021 Read SHALL have priority over write: IN_READY = !RST & !rd_go & (sram_cnt!=32).
REQ-022 For a read: SRAM_CSB=0, SRAM_WEB=1, SRAM_A=rp. For a write (IN_VALID & IN_READY): SRAM_CSB=0, SRAM_WEB=0, SRAM_A=wp. Otherwise SRAM_CSB=1.
REQ-023 rd_inflight SHALL equal rd_go registered; when it is set, SRAM_O SHALL be appended to ob on that cycle's edge.
REQ-024 OUT_VALID = ob_cnt!=0; OUT_DATA = ob head; a pop SHALL remove the head. Pop and append on the same edge SHALL both take effect.
REQ-025 Latency without bypass: a word accepted at edge E0 into an empty FIFO SHALL be read at E1 and SHALL show OUT_VALID=1 after E2.
REQ-026 Sustained throughput SHALL be one word per 2 cycles when both sides are continuously active, since the port is single.
REQ-027 COUNT SHALL update on every edge: +1 per accepted push, -1 per pop; simultaneous push and pop leave it unchanged.
REQ-028 Order SHALL be strictly preserved; no word is dropped or duplicated.
REQ-029 IN_DATA SHALL be ignored when IN_READY=0; OUT_READY SHALL be ignored when OUT_VALID=0.

Reset
REQ-030 While RST=1, the block SHALL hold: wp=rp=0, sram_cnt=0, rd_inflight=0, ob_cnt=0, OUT_VALID=0, COUNT=0, IN_READY=0, SRAM_CSB=1.
REQ-031 Reset asserted mid-operation SHALL immediately discard all contents, including an in-flight read, whose SRAM_O SHALL NOT be captured. SRAM contents need no clearing.

Configuration
REQ-032 With SRAM_FIFO_CTRL_BYPASS_EN defined, a push SHALL be written directly into ob, skipping the SRAM, when sram_cnt==0, rd_inflight==0 and (ob_cnt - pop)<2. In that case OUT_VALID=1 after E0 and no SRAM access occurs.
REQ-033 Without SRAM_FIFO_CTRL_BYPASS_EN, every word SHALL pass through the SRAM per REQ-025.

Verification
REQ-034 Reset then a single push of 0x2_AAAA_5555_AAAA at E0 -> SRAM write at A=0; OUT_VALID rises after E2 with that data; COUNT=1 from E0 until the pop.
REQ-035 Fill with OUT_READY=0 and pushes of 0..33 -> COUNT reaches 34 and IN_READY=0. Drain -> outputs 0..33 in order, and wp/rp wrap 31->0 without error.
REQ-036 IN_VALID=1 and OUT_READY=1 continuously for 200 cycles -> no SRAM cycle has both read and write, order is intact, and throughput is 0.5 words per cycle.
REQ-037 RST pulsed while rd_inflight=1 and COUNT=5 -> COUNT=0 and OUT_VALID=0 immediately; the next push/pop sequence is clean with no stale word.
REQ-038 With SRAM_FIFO_CTRL_BYPASS_EN, a push into an empty FIFO -> OUT_VALID after E0 and SRAM_CSB stays 1. A third push while ob is full and not popping -> goes to the SRAM at A=0.
REQ-039 Random IN_VALID/OUT_READY over 10k cycles against a reference queue -> data and COUNT match every cycle, with the macro model connected.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sram_fifo_ctrl
//
// FIFO controller that keeps its words in an external single-port SRAM
// macro (DEPTH = 2**AW entries of WIDTH bits). A two-entry output buffer
// hides the one-cycle read latency of the macro. At most one SRAM access
// (read or write) happens per cycle, and a pending read always wins over
// a write.
//
// Optional feature (compile-time macro):
//   SRAM_FIFO_CTRL_BYPASS_EN - when the SRAM is empty and no read is in
//   flight, a pushed word is written straight into the output buffer,
//   skipping the macro. Without the macro every word goes through the SRAM.
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   in_valid   producer offers in_data
//   in_ready   controller accepts in_data this cycle
//   in_data    word to be written
//   out_valid  out_data holds the head word
//   out_ready  consumer takes the head word
//   out_data   head word
//   count      words held in SRAM + in-flight read + output buffer (0..34)
//   sram_a     macro address
//   sram_csb   macro chip select, active low
//   sram_web   macro write enable, active low
//   sram_oeb   macro output enable, tied low
//   sram_i     macro write data (always in_data)
//   sram_o     macro read data, valid the cycle after a read edge
// ---------------------------------------------------------------------------
module sram_fifo_ctrl #(
  parameter int WIDTH = 50,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [5:0]       count,
  output logic [AW-1:0]    sram_a,
  output logic             sram_csb,
  output logic             sram_web,
  output logic             sram_oeb,
  output logic [WIDTH-1:0] sram_i,
  input  logic [WIDTH-1:0] sram_o
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      sram_cnt;
  logic             rd_inflight;
  logic [1:0]       ob_cnt;
  logic [WIDTH-1:0] ob0;
  logic [WIDTH-1:0] ob1;

  logic             pop;
  logic             push;
  logic             rd_go;
  logic             byp;
  logic             sram_wr;
  logic             append;
  logic [WIDTH-1:0] app_data;
  logic [2:0]       ob_room_use;

  // Handshakes and the per-cycle arbitration of the single SRAM port.
  // ob_room_use is the output-buffer occupancy once this cycle's pop and the
  // in-flight read have settled; a new read is only issued if its word will
  // still have a slot when it lands one cycle later.
  always_comb begin
    pop         = out_valid & out_ready;
    ob_room_use = {1'b0, ob_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    rd_go       = (sram_cnt != '0) && (ob_room_use < 3'd2);
    in_ready    = !rst && !rd_go && (sram_cnt != FULL_CNT);
    push        = in_valid & in_ready;
  end

`ifdef SRAM_FIFO_CTRL_BYPASS_EN
  // A push skips the macro only if nothing older is in the SRAM or in flight,
  // otherwise ordering would break.
  assign byp = push && (sram_cnt == '0) && !rd_inflight &&
               ((ob_cnt - {1'b0, pop}) < 2'd2);
`else
  assign byp = 1'b0;
`endif

  assign sram_wr  = push & ~byp;
  // Bypass requires no read in flight, so the two append sources never collide.
  assign append   = rd_inflight | byp;
  assign app_data = rd_inflight ? sram_o : in_data;

  assign sram_csb = ~(rd_go | sram_wr);
  assign sram_web = ~sram_wr;
  assign sram_a   = rd_go ? rp : wp;
  assign sram_oeb = 1'b0;
  assign sram_i   = in_data;

  assign out_valid = (ob_cnt != 2'd0);
  assign out_data  = ob0;
  assign count     = 6'(sram_cnt) + {5'b0, rd_inflight} + {4'b0, ob_cnt};

  // Pointer and SRAM occupancy bookkeeping. A read and a write never share
  // a cycle, so sram_cnt moves by at most one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp          <= '0;
      rp          <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= rd_go;
      if (rd_go) begin
        rp       <= rp + AW'(1);
        sram_cnt <= sram_cnt - (AW + 1)'(1);
      end else if (sram_wr) begin
        wp       <= wp + AW'(1);
        sram_cnt <= sram_cnt + (AW + 1)'(1);
      end
    end
  end

  // Two-entry output buffer; ob0 is the head. Reset clears the occupancy
  // together with rd_inflight, so a read that was in flight is never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob_cnt <= 2'd0;
      ob0    <= '0;
      ob1    <= '0;
    end else begin
      unique case ({pop, append})
        2'b10: begin
          ob0    <= ob1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b01: begin
          if (ob_cnt == 2'd0) ob0 <= app_data;
          else                ob1 <= app_data;
          ob_cnt <= ob_cnt + 2'd1;
        end
        2'b11: begin
          if (ob_cnt == 2'd1) begin
            ob0 <= app_data;
          end else begin
            ob0 <= ob1;
            ob1 <= app_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_fifo_ctrl
//
// Directed and random checks of sram_fifo_ctrl driving a behavioural 32x50
// single-port SRAM model. Inputs change on the falling edge; outputs are
// sampled 1 ns later, well away from the rising edge where state changes.
// A reference queue holds the words the FIFO should contain.
// Honours SRAM_FIFO_CTRL_BYPASS_EN for the bypass-specific expectations.
// ---------------------------------------------------------------------------
module tb_sram_fifo_ctrl;

  localparam int WIDTH = 50;
  localparam int AW    = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [5:0]       count;
  logic [AW-1:0]    sram_a;
  logic             sram_csb;
  logic             sram_web;
  logic             sram_oeb;
  logic [WIDTH-1:0] sram_i;
  logic [WIDTH-1:0] sram_o;

  logic [WIDTH-1:0] mem [32];
  logic [WIDTH-1:0] mq [$];

  int n_checks;
  int n_fail;

  sram_fifo_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .sram_a    (sram_a),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb),
    .sram_i    (sram_i),
    .sram_o    (sram_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port macro: read data appears after the read edge.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else           sram_o      <= mem[sram_a];
    end
  end

  // Reference queue update for the edge that follows the current sample.
  task automatic model_update(input bit do_push, input bit do_pop, input logic [WIDTH-1:0] d);
    if (do_pop && mq.size() > 0) void'(mq.pop_front());
    if (do_push) mq.push_back(d);
  endtask

  // Brings the DUT back to empty between scenarios.
  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  // Reset holds everything empty and blocks pushes and SRAM access.
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 50'h3_0000_0000_0001;
    @(negedge clk);
    #1;
    n_checks++;
    if (count !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if (sram_csb !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_csb: got %b expected 1", sram_csb); end
    n_checks++;
    if (sram_oeb !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_oeb: got %b expected 0", sram_oeb); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    mq.delete();
  endtask

  // One word through an empty FIFO: write at A=0, read, then visible.
  task automatic test_single_push();
    logic [WIDTH-1:0] w;
    w = 50'h2_AAAA_5555_AAAA;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_in_ready: got %b expected 1", in_ready); end
`ifdef SRAM_FIFO_CTRL_BYPASS_EN
    n_checks++;
    if (sram_csb !== 1'b1) begin n_fail++; $display("[TB] FAIL single_bypass_csb: got %b expected 1", sram_csb); end
`else
    n_checks++;
    if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_a !== 5'd0)
      begin n_fail++; $display("[TB] FAIL single_write: csb=%b web=%b a=%0d expected csb=0 web=0 a=0", sram_csb, sram_web, sram_a); end
`endif
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (count !== 6'd1) begin n_fail++; $display("[TB] FAIL single_count_e0: got %0d expected 1", count); end
`ifdef SRAM_FIFO_CTRL_BYPASS_EN
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== w)
      begin n_fail++; $display("[TB] FAIL single_bypass_out: valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, w); end
`else
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_valid_e0: got %b expected 0", out_valid); end
    n_checks++;
    if (sram_csb !== 1'b0 || sram_web !== 1'b1 || sram_a !== 5'd0)
      begin n_fail++; $display("[TB] FAIL single_read: csb=%b web=%b a=%0d expected csb=0 web=1 a=0", sram_csb, sram_web, sram_a); end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 6'd1)
      begin n_fail++; $display("[TB] FAIL single_e1: valid=%b count=%0d expected valid=0 count=1", out_valid, count); end
`endif
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== w || count !== 6'd1)
      begin n_fail++; $display("[TB] FAIL single_e2: valid=%b data=%h count=%0d expected valid=1 data=%h count=1", out_valid, out_data, count, w); end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 6'd0)
      begin n_fail++; $display("[TB] FAIL single_popped: valid=%b count=%0d expected valid=0 count=0", out_valid, count); end
  endtask

  // Fill to 34 words with the consumer stalled, then drain in order.
  task automatic test_fill_drain();
    int nxt;
    int got;
    do_reset();
    nxt = 0;
    for (int c = 0; c < 200 && nxt < 34; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 50'(nxt);
      #1;
      n_checks++;
      if (count !== 6'(mq.size())) begin n_fail++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, mq.size()); end
      if (in_ready) begin
        model_update(1'b1, 1'b0, in_data);
        nxt++;
      end
    end
    n_checks++;
    if (nxt != 34) begin n_fail++; $display("[TB] FAIL fill_accepted: got %0d expected 34", nxt); end
    @(negedge clk);
    in_data = 50'd99;
    #1;
    n_checks++;
    if (count !== 6'd34 || in_ready !== 1'b0)
      begin n_fail++; $display("[TB] FAIL fill_full: count=%0d in_ready=%b expected count=34 in_ready=0", count, in_ready); end
    in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 300 && got < 34; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        n_checks++;
        if (out_data !== 50'(got)) begin n_fail++; $display("[TB] FAIL drain_order: got %0d expected %0d", out_data, got); end
        got++;
      end
    end
    n_checks++;
    if (got != 34) begin n_fail++; $display("[TB] FAIL drain_total: got %0d expected 34", got); end
    @(negedge clk);
    #1;
    n_checks++;
    if (count !== 6'd0 || out_valid !== 1'b0)
      begin n_fail++; $display("[TB] FAIL drain_empty: count=%0d valid=%b expected 0 0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  // Both sides always active: order intact, no read/write sharing a cycle.
  task automatic test_throughput();
    int npops;
    int seq;
    do_reset();
    npops = 0;
    seq   = 1000;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 50'(seq);
      #1;
      n_checks++;
      if (count !== 6'(mq.size())) begin n_fail++; $display("[TB] FAIL tput_count: got %0d expected %0d", count, mq.size()); end
      if (out_valid) begin
        n_checks++;
        if (mq.size() == 0 || out_data !== mq[0]) begin n_fail++; $display("[TB] FAIL tput_data: got %0d cycle %0d", out_data, c); end
        npops++;
      end
      if (!sram_csb && sram_web) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL tput_port_conflict: in_ready=%b during read, expected 0", in_ready); end
      end
`ifndef SRAM_FIFO_CTRL_BYPASS_EN
      if (in_ready) begin
        n_checks++;
        if (sram_csb !== 1'b0 || sram_web !== 1'b0)
          begin n_fail++; $display("[TB] FAIL tput_write_strobe: csb=%b web=%b expected 0 0", sram_csb, sram_web); end
      end
`endif
      if (in_ready) seq++;
      model_update(in_valid && in_ready, out_valid && out_ready, in_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
`ifdef SRAM_FIFO_CTRL_BYPASS_EN
    if (npops < 97) begin n_fail++; $display("[TB] FAIL tput_rate: got %0d pops expected at least 97", npops); end
`else
    if (npops < 97 || npops > 100) begin n_fail++; $display("[TB] FAIL tput_rate: got %0d pops expected 97..100", npops); end
`endif
  endtask

  // Reset while a read is in flight with five words held.
  task automatic test_reset_midop();
    logic [WIDTH-1:0] w;
    bit               reached;
    do_reset();
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 50'(c + 500);
      #1;
      if (count == 6'd6) begin
        reached  = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
      end else if (in_ready) begin
        model_update(1'b1, 1'b0, in_data);
      end
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("[TB] FAIL midop_reach6: count=%0d expected 6", count); end
    #1;
    n_checks++;
    if (sram_csb !== 1'b0 || sram_web !== 1'b1)
      begin n_fail++; $display("[TB] FAIL midop_read_issue: csb=%b web=%b expected 0 1", sram_csb, sram_web); end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (count !== 6'd5) begin n_fail++; $display("[TB] FAIL midop_count5: got %0d expected 5", count); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (count !== 6'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || sram_csb !== 1'b1)
      begin n_fail++; $display("[TB] FAIL midop_async_clear: count=%0d valid=%b in_ready=%b csb=%b expected 0 0 0 1", count, out_valid, in_ready, sram_csb); end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    @(negedge clk);
    #1;
    n_checks++;
    if (count !== 6'd0 || out_valid !== 1'b0)
      begin n_fail++; $display("[TB] FAIL midop_no_stale: count=%0d valid=%b expected 0 0", count, out_valid); end
    w = 50'h0_1234_5678_9ABC;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4 && !out_valid; c++) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== w || count !== 6'd1)
      begin n_fail++; $display("[TB] FAIL midop_fresh_word: valid=%b data=%h count=%0d expected 1 %h 1", out_valid, out_data, count, w); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (count !== 6'd0 || out_valid !== 1'b0)
      begin n_fail++; $display("[TB] FAIL midop_final_empty: count=%0d valid=%b expected 0 0", count, out_valid); end
  endtask

`ifdef SRAM_FIFO_CTRL_BYPASS_EN
  // Two pushes land in the output buffer directly; the third uses SRAM A=0.
  task automatic test_bypass();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 50'hA1;
    #1;
    n_checks++;
    if (sram_csb !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_first_csb: got %b expected 1", sram_csb); end
    @(negedge clk);
    in_data = 50'hB2;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 50'hA1 || sram_csb !== 1'b1)
      begin n_fail++; $display("[TB] FAIL bypass_second: valid=%b data=%h csb=%b expected 1 a1 1", out_valid, out_data, sram_csb); end
    @(negedge clk);
    in_data = 50'hC3;
    #1;
    n_checks++;
    if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_a !== 5'd0)
      begin n_fail++; $display("[TB] FAIL bypass_third_to_sram: csb=%b web=%b a=%0d expected 0 0 0", sram_csb, sram_web, sram_a); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (count !== 6'd3) begin n_fail++; $display("[TB] FAIL bypass_count: got %0d expected 3", count); end
  endtask
`endif

  // Random traffic against the reference queue, then drained.
  task automatic test_random();
    logic [63:0] r;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      r         = {$urandom, $urandom};
      in_valid  = r[63];
      out_ready = r[62];
      in_data   = r[49:0];
      #1;
      n_checks++;
      if (count !== 6'(mq.size())) begin n_fail++; $display("[TB] FAIL rand_count: got %0d expected %0d cycle %0d", count, mq.size(), c); end
      if (out_valid) begin
        n_checks++;
        if (mq.size() == 0 || out_data !== mq[0]) begin n_fail++; $display("[TB] FAIL rand_data: got %h cycle %0d", out_data, c); end
      end
      model_update(in_valid && in_ready, out_valid && out_ready, in_data);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 200 && mq.size() > 0; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        n_checks++;
        if (out_data !== mq[0]) begin n_fail++; $display("[TB] FAIL rand_drain_data: got %h expected %h", out_data, mq[0]); end
      end
      model_update(1'b0, out_valid && out_ready, in_data);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (count !== 6'd0 || mq.size() != 0)
      begin n_fail++; $display("[TB] FAIL rand_drain_empty: count=%0d model=%0d expected 0 0", count, mq.size()); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_throughput();
    test_reset_midop();
`ifdef SRAM_FIFO_CTRL_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
